alu_share_arbiter: RTL
======================

Name: alu_share_arbiter

Overview:
- Shares one 8-bit combinational ALU (sel-encoded ops; outputs f, ovf, take_branch) between two independent requesters.
- Arbitrates round-robin, registers the operands, drives the ALU, captures its outputs and returns a response to the granted requester with valid/ready handshakes.
- Sits between the two issue units and the single ALU instance.

Parameters:
- DATA_W, 8, operand/result width; must match the ALU.
- SEL_W, 3, ALU operation select width.
- CNT_W, 16, width of the completed-operation and overflow statistics counters.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- req0_valid  input  1  requester 0 has an op.
- req0_ready  output  1  arbiter accepts requester 0's op this cycle.
- req0_a  input  DATA_W  operand a.
- req0_b  input  DATA_W  operand b.
- req0_sel  input  SEL_W  ALU op.
- rsp0_valid  output  1  response for requester 0 available.
- rsp0_ready  input  1  requester 0 takes the response.
- rsp0_f  output  DATA_W  result.
- rsp0_ovf  output  1  overflow flag.
- rsp0_br  output  1  take_branch flag.
- req1_* / rsp1_*  as above  requester 1.
- alu_a  output  DATA_W  to ALU a.
- alu_b  output  DATA_W  to ALU b.
- alu_sel  output  SEL_W  to ALU sel.
- alu_f  input  DATA_W  ALU result.
- alu_ovf  input  1  ALU ovf.
- alu_take_branch  input  1  ALU take_branch.
- busy  output  1  state is not IDLE.
- grant_id  output  1  requester owning the current op.
- op_count  output  CNT_W  completed responses; saturating.
- ovf_count  output  CNT_W  completed responses with ovf=1; saturating.

Behaviour:
- **Reset** (rst_n=0 at a clk edge):
  - state=IDLE; op registers, alu_a/b/sel and result registers = 0.
  - grant_id=0; last_grant=1, so requester 0 wins the first tie.
  - Counters = 0; all ready/valid outputs = 0.
  - Reset mid-operation abandons the op: no response is ever issued for it.
- **FSM states:** IDLE -> EXEC -> RESP -> IDLE.
- **IDLE arbitration:**
  - Winner is the single valid requester.
  - If both are valid, the winner is the requester != last_grant.
  - reqN_ready = (state==IDLE) & (winner==N), combinational. The loser's ready is 0.
  - On valid&ready: latch a/b/sel into op registers, set grant_id=winner, go to EXEC.
  - valid dropped before acceptance is legal and is not remembered.
- **ALU drive:** alu_a/b/sel are driven only from the op registers (never combinationally from the requesters) and hold their values outside EXEC.
- **EXEC:** exactly one cycle. At the end of the cycle, capture alu_f, alu_ovf and alu_take_branch into the result registers, then go to RESP.
- **RESP:**
  - rsp[grant_id]_valid=1 with f/ovf/br held stable; the other requester's rsp_valid=0.
  - rsp_f/ovf/br of the non-granted requester are 0.
  - Wait indefinitely for rsp_ready. No new request is accepted while waiting (all req_ready=0).
  - On rsp_valid&rsp_ready: last_grant=grant_id, op_count+1, ovf_count+ovf, then go to IDLE.
- **Latency:**
  - Accept at edge T; rsp_valid high from the cycle after edge T+1.
  - Best case is one op per 3 cycles.
  - Acceptance in IDLE happens in the same cycle a request appears.
- **Fairness:**
  - With both requesters continuously valid, grants strictly alternate 0,1,0,1.
  - A lone requester is served back-to-back with no penalty.
- **Counters:** saturate at all-ones and never wrap.

Test Plan:
- Reset, then req0 {a=0x70, b=0x20, sel=000} with rsp0_ready=1 -> req0_ready=1 in the request cycle; rsp0_valid two edges later with f=0x90, ovf=1, br=0; op_count=1, ovf_count=1.
- Both requesters valid for 4 ops each -> grant order 0,1,0,1,...; each rsp carries its own result (req1 {a=0x0F, b=0xF0, sel=011} -> f=0xFF); rsp0_valid and rsp1_valid are never both 1.
- Hold rsp1_ready=0 for 10 cycles after a req1 op {sel=110, a=b=0x33} -> rsp1_valid held with br=1; req0_ready stays 0 throughout; completion on the first ready cycle.
- Pulse rst_n=0 during EXEC -> no rsp_valid on either port; counters=0; next op is granted to req0 even if both requesters are valid.
- Force op_count to saturate (or use CNT_W=2) and run 5 ops -> counter stays at 3.
- req0 valid for 1 cycle while the arbiter is in RESP, then dropped -> the op is never executed; op_count is unchanged.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Purpose : shares one combinational 8-bit ALU between two requesters. Arbitration is
//           round-robin, and the operands and results are registered.
// Latency : an op is accepted at edge T, the ALU output is captured at T+1, and rsp_valid
//           is high from T+1 onward. At best one op completes every 3 cycles.
// Backpr. : waits in RESP for as long as rsp_ready stays low. While it waits, both
//           req_ready outputs are held at 0.
// Ports   : req{0,1}_* are the request valid/ready pair and operands.
//           rsp{0,1}_* are the response valid/ready pair and results.
//           alu_* connect to the ALU.
//           busy, grant_id, op_count and ovf_count are status outputs.
module alu_share_arbiter #(
  parameter int DATA_W = 8,
  parameter int SEL_W  = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [SEL_W-1:0]  req0_sel,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_f,
  output logic              rsp0_ovf,
  output logic              rsp0_br,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [SEL_W-1:0]  req1_sel,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_f,
  output logic              rsp1_ovf,
  output logic              rsp1_br,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [SEL_W-1:0]  alu_sel,
  input  logic [DATA_W-1:0] alu_f,
  input  logic              alu_ovf,
  input  logic              alu_take_branch,
  output logic              busy,
  output logic              grant_id,
  output logic [CNT_W-1:0]  op_count,
  output logic [CNT_W-1:0]  ovf_count
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_last_grant;
  logic               r_grant;
  logic [DATA_W-1:0]  r_op_a;
  logic [DATA_W-1:0]  r_op_b;
  logic [SEL_W-1:0]   r_op_sel;
  logic [DATA_W-1:0]  r_f;
  logic               r_ovf;
  logic               r_br;
  logic [CNT_W-1:0]   r_op_count;
  logic [CNT_W-1:0]   r_ovf_count;

  logic               w_win;
  logic               w_accept;
  logic               w_rsp_done;

  // When both requesters are valid, the one that was not served last wins.
  always_comb begin
    w_win = 1'b0;
    if (req0_valid && req1_valid) w_win = ~r_last_grant;
    else if (req1_valid)          w_win = 1'b1;
  end

  assign w_accept   = (r_state == IDLE) && (w_win ? req1_valid : req0_valid);
  assign w_rsp_done = (r_state == RESP) && (r_grant ? rsp1_ready : rsp0_ready);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = EXEC;
      EXEC:    w_next = RESP;
      RESP:    if (w_rsp_done) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Output logic. The responder that is not granted sees all-zero data.
  always_comb begin
    req0_ready = (r_state == IDLE) && req0_valid && !w_win;
    req1_ready = (r_state == IDLE) && req1_valid &&  w_win;
    rsp0_valid = (r_state == RESP) && !r_grant;
    rsp1_valid = (r_state == RESP) &&  r_grant;
    rsp0_f     = rsp0_valid ? r_f : '0;
    rsp0_ovf   = rsp0_valid & r_ovf;
    rsp0_br    = rsp0_valid & r_br;
    rsp1_f     = rsp1_valid ? r_f : '0;
    rsp1_ovf   = rsp1_valid & r_ovf;
    rsp1_br    = rsp1_valid & r_br;
    busy       = (r_state != IDLE);
  end

  // Datapath: operand latch, result capture, grant history and counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_op_sel     <= '0;
      r_f          <= '0;
      r_ovf        <= 1'b0;
      r_br         <= 1'b0;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;  // requester 0 wins the first tie
      r_op_count   <= '0;
      r_ovf_count  <= '0;
    end else begin
      if (w_accept) begin
        r_op_a   <= w_win ? req1_a   : req0_a;
        r_op_b   <= w_win ? req1_b   : req0_b;
        r_op_sel <= w_win ? req1_sel : req0_sel;
        r_grant  <= w_win;
      end
      if (r_state == EXEC) begin
        r_f   <= alu_f;
        r_ovf <= alu_ovf;
        r_br  <= alu_take_branch;
      end
      if (w_rsp_done) begin
        r_last_grant <= r_grant;
        if (r_op_count != {CNT_W{1'b1}})
          r_op_count <= r_op_count + 1'b1;
        if (r_ovf && (r_ovf_count != {CNT_W{1'b1}}))
          r_ovf_count <= r_ovf_count + 1'b1;
      end
    end
  end

  // The ALU sees only the registered operands, so its inputs stay stable outside EXEC.
  assign alu_a     = r_op_a;
  assign alu_b     = r_op_b;
  assign alu_sel   = r_op_sel;
  assign grant_id  = r_grant;
  assign op_count  = r_op_count;
  assign ovf_count = r_ovf_count;

endmodule
